// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one pipelined fixed-point multiplier among NUM_REQ
// requesters. Requesters are granted round-robin, at most one issue per cycle.
// A LATENCY-deep tag pipe carries each requester ID alongside the multiplier.
// Results land in a FIFO whose free space is reserved up front by a credit
// check, so consumer backpressure never loses a product that is in flight.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   reqValid/reqReady    per-requester handshake; reqReady is one-hot or zero
//   reqIn1/reqIn2        packed signed operands, requester k at slice k
//   mulIn1/mulIn2        registered operands to the external multiplier
//   mulOut/mulOvf        product and overflow, LATENCY cycles after issue
//   rspValid/rspReady    result handshake (first-word-fall-through FIFO head)
//   rspId/rspData/rspOvf requester ID, product and overflow of the head entry
//   ovfCount             saturating count of overflowed products written to
//                        the FIFO; present only when FP_MUL_ARB_OVF_COUNT_EN
//                        is defined
module fp_mul_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WI1        = 3,
  parameter int unsigned WF1        = 4,
  parameter int unsigned WI2        = 4,
  parameter int unsigned WF2        = 3,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    reqValid,
  output logic [NUM_REQ-1:0]                    reqReady,
  input  logic [NUM_REQ*(WI1+WF1)-1:0]          reqIn1,
  input  logic [NUM_REQ*(WI2+WF2)-1:0]          reqIn2,
  output logic [WI1+WF1-1:0]                    mulIn1,
  output logic [WI2+WF2-1:0]                    mulIn2,
  input  logic [WI1+WI2+WF1+WF2-1:0]            mulOut,
  input  logic                                  mulOvf,
  output logic                                  rspValid,
  input  logic                                  rspReady,
  output logic [$clog2(NUM_REQ)-1:0]            rspId,
  output logic [WI1+WI2+WF1+WF2-1:0]            rspData,
  output logic                                  rspOvf
`ifdef FP_MUL_ARB_OVF_COUNT_EN
  ,
  output logic [15:0]                           ovfCount
`endif
);

  localparam int unsigned W1 = WI1 + WF1;
  localparam int unsigned W2 = WI2 + WF2;
  localparam int unsigned WP = WI1 + WI2 + WF1 + WF2;
  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  // Arbitration state
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      grant_idx;
  logic               grant_found;
  logic               issue_ok;
  logic               xfer;
  logic [W1-1:0]      sel_in1;
  logic [W2-1:0]      sel_in2;

  // Tag pipe
  logic [LATENCY-1:0] tag_v;
  logic [IW-1:0]      tag_id [LATENCY];
  logic [CW-1:0]      inflight;
  logic               wr;

  // Result FIFO
  logic [IW-1:0]      fifo_id   [FIFO_DEPTH];
  logic [WP-1:0]      fifo_data [FIFO_DEPTH];
  logic               fifo_ovf  [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               pop;

  // Credit check on registered occupancy: FIFO entries plus products in flight
  assign issue_ok = (SW'(count) + SW'(inflight)) < SW'(FIFO_DEPTH);

  // Round-robin search starting at ptr
  always_comb begin
    int unsigned cand;
    logic [IW-1:0] cand_idx;
    cand        = 0;
    cand_idx    = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IW'(cand);
      if (!grant_found && reqValid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Winner operand mux
  always_comb begin
    sel_in1 = '0;
    sel_in2 = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IW'(k)) begin
        sel_in1 = reqIn1[k*W1 +: W1];
        sel_in2 = reqIn2[k*W2 +: W2];
      end
    end
  end

  assign xfer     = !rst && grant_found && issue_ok;
  assign reqReady = xfer ? (NUM_REQ'(1) << grant_idx) : '0;

  assign wr       = tag_v[LATENCY-1];
  assign rspValid = !rst && (count != '0);
  assign pop      = rspValid && rspReady;
  assign rspId    = rspValid ? fifo_id[rd_ptr]   : '0;
  assign rspData  = rspValid ? fifo_data[rd_ptr] : '0;
  assign rspOvf   = rspValid ? fifo_ovf[rd_ptr]  : 1'b0;

  // Control registers: pointer, operands, tag pipe, occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      mulIn1   <= '0;
      mulIn2   <= '0;
      tag_v    <= '0;
      inflight <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (xfer) begin
        ptr    <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
        mulIn1 <= sel_in1;
        mulIn2 <= sel_in2;
      end
      tag_v[0] <= xfer;
      for (int unsigned k = 1; k < LATENCY; k++) tag_v[k] <= tag_v[k-1];
      inflight <= inflight + CW'(xfer) - CW'(wr);
      count    <= count + CW'(wr) - CW'(pop);
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Tag IDs and FIFO storage need no reset; validity lives in tag_v and count
  always_ff @(posedge clk) begin
    tag_id[0] <= grant_idx;
    for (int unsigned k = 1; k < LATENCY; k++) tag_id[k] <= tag_id[k-1];
    if (wr) begin
      fifo_id[wr_ptr]   <= tag_id[LATENCY-1];
      fifo_data[wr_ptr] <= mulOut;
      fifo_ovf[wr_ptr]  <= mulOvf;
    end
  end

`ifdef FP_MUL_ARB_OVF_COUNT_EN
  // Saturating overflow counter over products accepted into the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      ovfCount <= '0;
    end else if (wr && mulOvf && (ovfCount != 16'hFFFF)) begin
      ovfCount <= ovfCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
module tb_fp_mul_arbiter;

  localparam int N   = 4;
  localparam int WI1 = 3;
  localparam int WF1 = 4;
  localparam int WI2 = 4;
  localparam int WF2 = 3;
  localparam int LAT = 3;
  localparam int FD  = 4;
  localparam int W1  = WI1 + WF1;
  localparam int W2  = WI2 + WF2;
  localparam int WP  = W1 + W2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      reqValid;
  logic [N-1:0]      reqReady;
  logic [N*W1-1:0]   reqIn1;
  logic [N*W2-1:0]   reqIn2;
  logic [W1-1:0]     mulIn1;
  logic [W2-1:0]     mulIn2;
  logic [WP-1:0]     mulOut;
  logic              mulOvf;
  logic              rspValid;
  logic              rspReady;
  logic [1:0]        rspId;
  logic [WP-1:0]     rspData;
  logic              rspOvf;
`ifdef FP_MUL_ARB_OVF_COUNT_EN
  logic [15:0]       ovfCount;
`endif

  fp_mul_arbiter #(
    .NUM_REQ(N), .WI1(WI1), .WF1(WF1), .WI2(WI2), .WF2(WF2),
    .LATENCY(LAT), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqIn1(reqIn1), .reqIn2(reqIn2),
    .mulIn1(mulIn1), .mulIn2(mulIn2),
    .mulOut(mulOut), .mulOvf(mulOvf),
    .rspValid(rspValid), .rspReady(rspReady),
    .rspId(rspId), .rspData(rspData), .rspOvf(rspOvf)
`ifdef FP_MUL_ARB_OVF_COUNT_EN
    , .ovfCount(ovfCount)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: product appears LAT cycles after the issue cycle.
  // Overflow is modelled as the parity of the product so it varies per result.
  logic signed [WP-1:0] mp [LAT-1];
  always @(posedge clk) begin
    mp[0] <= $signed(mulIn1) * $signed(mulIn2);
    for (int i = 1; i < LAT - 1; i++) mp[i] <= mp[i-1];
  end
  assign mulOut = mp[LAT-2];
  assign mulOvf = ^mulOut;

  typedef struct {
    int            id;
    logic [WP-1:0] data;
    logic          ovf;
    int            rdy_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   mptr = 0;
  int   issued = 0;
  int   popped = 0;
  int   ovf_exp = 0;
  bit   mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp_v);
    end
  endtask

  // Reference model: credit = depth minus (issued - popped), round-robin pick,
  // product by plain signed multiplication, result due LAT+1 cycles later.
  task automatic model_step();
    logic [N-1:0]         er;
    bit                   found;
    int                   g;
    int                   idx;
    logic signed [W1-1:0] x;
    logic signed [W2-1:0] y;
    logic signed [WP-1:0] p;
    er = '0;
    found = 0;
    g = 0;
    if (rst) begin
      exp_q.delete();
      mptr = 0;
      issued = 0;
      popped = 0;
      ovf_exp = 0;
    end else if ((issued - popped) < FD) begin
      for (int i = 0; i < N; i++) begin
        idx = (mptr + i) % N;
        if (!found && reqValid[2'(idx)]) begin
          found = 1;
          g = idx;
        end
      end
      if (found) er[2'(g)] = 1'b1;
    end
    chk("reqReady", longint'(reqReady), longint'(er));
    if (found) begin
      x = reqIn1[g*W1 +: W1];
      y = reqIn2[g*W2 +: W2];
      p = x * y;
      exp_q.push_back('{id: g, data: p, ovf: ^p, rdy_cyc: cyc + LAT + 1});
      issued++;
      if (^p) ovf_exp++;
      mptr = (g + 1) % N;
    end
  endtask

  task automatic do_cycle(input logic r, input logic [N-1:0] v,
                          input logic [N*W1-1:0] a, input logic [N*W2-1:0] b,
                          input logic rr);
    @(posedge clk);
    #1;
    rst = r;
    reqValid = v;
    reqIn1 = a;
    reqIn2 = b;
    rspReady = rr;
    #2;
    model_step();
  endtask

  // Monitor: compares the FIFO head against the oldest expected result
  always @(negedge clk) begin
    if (mon_en) begin
      bit ev;
      ev = !rst && (exp_q.size() > 0) && (exp_q[0].rdy_cyc <= cyc);
      chk("rspValid", longint'(rspValid), longint'(ev));
      if (ev && rspValid) begin
        chk("rspId",   longint'(rspId),   longint'(exp_q[0].id));
        chk("rspData", longint'(rspData), longint'(exp_q[0].data));
        chk("rspOvf",  longint'(rspOvf),  longint'(exp_q[0].ovf));
      end
      if (ev && rspReady) begin
        void'(exp_q.pop_front());
        popped++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  logic [N*W1-1:0] ra;
  logic [N*W2-1:0] rb;
  int              xfers;

  initial begin
    rst = 1'b1;
    reqValid = '0;
    reqIn1 = '0;
    reqIn2 = '0;
    rspReady = 1'b0;
    mon_en = 1;
    do_cycle(1'b1, '0, '0, '0, 1'b1);
    do_cycle(1'b1, '0, '0, '0, 1'b1);
    chk("rst_mulIn1",  longint'(mulIn1),  0);
    chk("rst_mulIn2",  longint'(mulIn2),  0);
    chk("rst_rspId",   longint'(rspId),   0);
    chk("rst_rspData", longint'(rspData), 0);
    chk("rst_rspOvf",  longint'(rspOvf),  0);

    // Single requester 0: in1=0x12, in2=0x0B
    do_cycle(1'b0, 4'b0001, 28'h12, 28'h0B, 1'b1);
    repeat (6) do_cycle(1'b0, '0, '0, '0, 1'b1);

    // All requesters continuously valid, consumer always ready
    for (int i = 0; i < 12; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      do_cycle(1'b0, 4'b1111, ra, rb, 1'b1);
    end
    repeat (6) do_cycle(1'b0, '0, '0, '0, 1'b1);

    // Backpressure: exactly FIFO_DEPTH issues while the consumer stalls
    xfers = 0;
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      do_cycle(1'b0, 4'b1111, ra, rb, 1'b0);
      if ((reqReady & reqValid) != '0) xfers++;
    end
    chk("bp_issue_count", longint'(xfers), longint'(FD));
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      do_cycle(1'b0, 4'b1111, ra, rb, 1'b1);
    end
    repeat (8) do_cycle(1'b0, '0, '0, '0, 1'b1);

    // Reset two cycles after an issue: late product must be dropped
    do_cycle(1'b0, 4'b0010, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    do_cycle(1'b0, '0, '0, '0, 1'b1);
    do_cycle(1'b0, '0, '0, '0, 1'b1);
    do_cycle(1'b1, '0, '0, '0, 1'b1);
    repeat (5) do_cycle(1'b0, '0, '0, '0, 1'b1);
    do_cycle(1'b0, 4'b1111, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    repeat (6) do_cycle(1'b0, '0, '0, '0, 1'b1);

    // Grant 3, then requester 2 alone, then 2 and 3 together (pointer at 3)
    do_cycle(1'b0, 4'b1000, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    do_cycle(1'b0, 4'b0100, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    do_cycle(1'b0, 4'b1100, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    repeat (6) do_cycle(1'b0, '0, '0, '0, 1'b1);

    // Randomized traffic with backpressure and occasional reset
    for (int i = 0; i < 1500; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      do_cycle(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
               4'($urandom), ra, rb,
               ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    repeat (20) do_cycle(1'b0, '0, '0, '0, 1'b1);
    chk("drained_rspValid", longint'(rspValid), 0);
`ifdef FP_MUL_ARB_OVF_COUNT_EN
    chk("ovfCount", longint'(ovfCount), longint'(ovf_exp));
`endif

    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
